// File: rtl/stall_scheduler.sv
// Pipeline stall/flush scheduler: sequences the divider and the imem/dmem handshakes,
// and merges them with load-use and exception commit into per-stage Stall*/Flush*.
module stall_scheduler #(
  parameter int unsigned DIV_LAT = 33
) (
  input  logic clk,
  input  logic rst,
  input  logic LoadUseD,
  input  logic DivE,
  input  logic ExceptM,
  input  logic IAddrOk,
  input  logic IDataOk,
  input  logic DMemM,
  input  logic DAddrOk,
  input  logic DDataOk,
  output logic IReq,
  output logic IDiscard,
  output logic DReq,
  output logic DBusy,
  output logic DivStart,
  output logic DivDoneE,
  output logic StallF,
  output logic StallD,
  output logic StallE,
  output logic StallM,
  output logic StallW,
  output logic FlushD,
  output logic FlushE,
  output logic FlushM,
  output logic FlushW
);

  localparam int unsigned CNT_W = 6;
  // Counter holds the busy cycles left before the DivDoneE cycle.
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 2);

  typedef enum logic [1:0] {DV_IDLE, DV_BUSY, DV_DONE} dv_state_e;
  typedef enum logic [1:0] {DM_IDLE, DM_ADDR, DM_DATA} dm_state_e;
  typedef enum logic [1:0] {IM_ADDR, IM_DATA, IM_HOLD} im_state_e;

  dv_state_e        dv_q, dv_d;
  dm_state_e        dm_q, dm_d;
  im_state_e        im_q, im_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             discard_q, discard_d;

  logic div_start, div_done, div_stall;
  logic d_req, d_stall;
  logic i_req, i_beat, i_disc, i_stall, non_i;
  logic stall_f, stall_d, stall_e, stall_m;
  logic flush_d, flush_e, flush_m, flush_w;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dv_q      <= DV_IDLE;
      dm_q      <= DM_IDLE;
      im_q      <= IM_ADDR;
      cnt_q     <= '0;
      discard_q <= 1'b0;
    end else begin
      dv_q      <= dv_d;
      dm_q      <= dm_d;
      im_q      <= im_d;
      cnt_q     <= cnt_d;
      discard_q <= discard_d;
    end
  end

  always_comb begin
    dv_d      = dv_q;
    dm_d      = dm_q;
    im_d      = im_q;
    cnt_d     = cnt_q;
    discard_d = discard_q;
    stall_f   = 1'b0;
    stall_d   = 1'b0;
    stall_e   = 1'b0;
    stall_m   = 1'b0;
    flush_d   = 1'b0;
    flush_e   = 1'b0;
    flush_m   = 1'b0;
    flush_w   = 1'b0;

    div_start = (dv_q == DV_IDLE) && DivE && !ExceptM;
    div_done  = (dv_q == DV_BUSY) && (cnt_q == '0);
    div_stall = ((dv_q == DV_IDLE) && DivE) || ((dv_q == DV_BUSY) && (cnt_q != '0));

    d_req   = ((dm_q == DM_IDLE) && DMemM && !ExceptM) || (dm_q == DM_ADDR);
    d_stall = d_req || ((dm_q == DM_DATA) && !DDataOk);

    i_req   = (im_q == IM_ADDR);
    i_beat  = (im_q == IM_DATA) && IDataOk && !discard_q;
    i_disc  = (im_q == IM_DATA) && IDataOk && discard_q;
    i_stall = !i_beat && (im_q != IM_HOLD);

    // Exception commit overrides everything except the fetch handshake.
    if (ExceptM) begin
      stall_f = i_stall;
      flush_d = 1'b1;
      flush_e = 1'b1;
      flush_m = 1'b1;
      flush_w = 1'b1;
    end else begin
      stall_f = i_stall || div_stall || d_stall || LoadUseD;
      stall_d = div_stall || d_stall || LoadUseD;
      stall_e = div_stall || d_stall;
      stall_m = d_stall;
      flush_d = i_stall && !stall_d;
      flush_e = LoadUseD && !stall_e;
      flush_m = div_stall && !d_stall;
      flush_w = d_stall;
    end
    non_i = !ExceptM && (div_stall || d_stall || LoadUseD);

    case (dv_q)
      DV_IDLE: begin
        if (div_start) begin
          dv_d  = DV_BUSY;
          cnt_d = DIV_LOAD;
        end
      end
      DV_BUSY: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        else             dv_d  = stall_e ? DV_DONE : DV_IDLE;
      end
      DV_DONE: if (!stall_e) dv_d = DV_IDLE;
      default: dv_d = DV_IDLE;
    endcase
    if (ExceptM) begin
      dv_d  = DV_IDLE;
      cnt_d = '0;
    end

    case (dm_q)
      DM_IDLE: if (d_req) dm_d = DAddrOk ? DM_DATA : DM_ADDR;
      DM_ADDR: if (DAddrOk) dm_d = DM_DATA;
      DM_DATA: if (DDataOk) dm_d = DM_IDLE;
      default: dm_d = DM_IDLE;
    endcase

    case (im_q)
      IM_ADDR: if (IAddrOk) im_d = IM_DATA;
      IM_DATA: begin
        if (IDataOk) begin
          discard_d = 1'b0;
          im_d      = (!discard_q && non_i) ? IM_HOLD : IM_ADDR;
        end else if (ExceptM) begin
          discard_d = 1'b1;
        end
      end
      IM_HOLD: if (!non_i) im_d = IM_ADDR;
      default: im_d = IM_ADDR;
    endcase
  end

  // Everything is forced quiet while reset is held.
  assign IReq     = rst & i_req;
  assign IDiscard = rst & i_disc;
  assign DReq     = rst & d_req;
  assign DBusy    = rst & (dm_q != DM_IDLE);
  assign DivStart = rst & div_start;
  assign DivDoneE = rst & div_done;
  assign StallF   = rst & stall_f;
  assign StallD   = rst & stall_d;
  assign StallE   = rst & stall_e;
  assign StallM   = rst & stall_m;
  assign StallW   = 1'b0;
  assign FlushD   = rst & flush_d;
  assign FlushE   = rst & flush_e;
  assign FlushM   = rst & flush_m;
  assign FlushW   = rst & flush_w;

endmodule

// File: tb/tb_stall_scheduler.sv
// Bench for stall_scheduler: directed scenarios with literal expectations, then random
// stimulus checked every cycle against a cycle-count based behavioural model.
module tb_stall_scheduler;

  localparam int unsigned DIV_LAT = 33;

  logic clk = 1'b0;
  logic rst, LoadUseD, DivE, ExceptM, IAddrOk, IDataOk, DMemM, DAddrOk, DDataOk;
  logic IReq, IDiscard, DReq, DBusy, DivStart, DivDoneE;
  logic StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, FlushM, FlushW;

  stall_scheduler #(.DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst(rst), .LoadUseD(LoadUseD), .DivE(DivE), .ExceptM(ExceptM),
    .IAddrOk(IAddrOk), .IDataOk(IDataOk), .DMemM(DMemM), .DAddrOk(DAddrOk), .DDataOk(DDataOk),
    .IReq(IReq), .IDiscard(IDiscard), .DReq(DReq), .DBusy(DBusy), .DivStart(DivStart),
    .DivDoneE(DivDoneE), .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .StallW(StallW), .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW)
  );

  always #5 clk = ~clk;

  logic [14:0] act;
  assign act = {IReq, IDiscard, DReq, DBusy, DivStart, DivDoneE, StallF, StallD, StallE,
                StallM, StallW, FlushD, FlushE, FlushM, FlushW};

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: divider as start timestamp, memories as outstanding-transaction flags.
  int unsigned cyc = 0;
  int unsigned dv_t0 = 0;
  bit dv_act = 0, dv_wait = 0;
  bit dm_grant = 0, dm_data = 0;
  bit im_fly = 0, im_park = 0, im_cancel = 0;

  bit m_start, m_done, m_dreq, m_dbusy, m_ireq, m_idisc, m_noni;
  bit m_sf, m_sd, m_se, m_sm, m_fd, m_fe, m_fm, m_fw;
  logic [14:0] exp_v;

  task automatic model_eval();
    bit idle, dstall, divstall, istall, beat;
    idle     = !dv_act && !dv_wait;
    m_start  = idle && DivE && !ExceptM;
    m_done   = dv_act && ((cyc - dv_t0) == DIV_LAT - 1);
    divstall = (idle && DivE) || (dv_act && !m_done);
    m_dreq   = dm_grant || (!dm_data && DMemM && !ExceptM);
    m_dbusy  = dm_grant || dm_data;
    dstall   = m_dreq || (dm_data && !DDataOk);
    m_ireq   = !im_fly && !im_park;
    beat     = im_fly && IDataOk && !im_cancel;
    m_idisc  = im_fly && IDataOk && im_cancel;
    istall   = !beat && !im_park;
    if (ExceptM) begin
      m_sf = istall; m_sd = 0; m_se = 0; m_sm = 0;
      m_fd = 1; m_fe = 1; m_fm = 1; m_fw = 1;
    end else begin
      m_sd = divstall || dstall || LoadUseD;
      m_sf = istall || m_sd;
      m_se = divstall || dstall;
      m_sm = dstall;
      m_fd = istall && !m_sd;
      m_fe = LoadUseD && !m_se;
      m_fm = divstall && !dstall;
      m_fw = dstall;
    end
    m_noni = !ExceptM && (divstall || dstall || LoadUseD);
    exp_v = {m_ireq, m_idisc, m_dreq, m_dbusy, m_start, m_done, m_sf, m_sd, m_se,
             m_sm, 1'b0, m_fd, m_fe, m_fm, m_fw};
    if (!rst) exp_v = '0;
  endtask

  task automatic model_update();
    if (!rst) begin
      dv_act = 0; dv_wait = 0; dm_grant = 0; dm_data = 0;
      im_fly = 0; im_park = 0; im_cancel = 0;
    end else begin
      if (ExceptM) begin
        dv_act = 0; dv_wait = 0;
      end else if (m_start) begin
        dv_act = 1; dv_t0 = cyc;
      end else if (m_done) begin
        dv_act = 0; dv_wait = m_se;
      end else if (dv_wait && !m_se) begin
        dv_wait = 0;
      end
      if (m_dreq && DAddrOk) begin
        dm_grant = 0; dm_data = 1;
      end else if (m_dreq) begin
        dm_grant = 1;
      end else if (dm_data && DDataOk) begin
        dm_data = 0;
      end
      if (m_ireq) begin
        if (IAddrOk) im_fly = 1;
      end else if (im_fly) begin
        if (IDataOk) begin
          im_fly = 0; im_park = !im_cancel && m_noni; im_cancel = 0;
        end else if (ExceptM) begin
          im_cancel = 1;
        end
      end else if (!m_noni) begin
        im_park = 0;
      end
    end
    cyc++;
  endtask

  // Sample at the falling edge, compare the full output vector, then advance the model.
  task automatic step();
    @(negedge clk);
    model_eval();
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL cycle %0d outputs: got %b expected %b", cyc, act, exp_v);
    model_update();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic a, input logic e);
    n_checks++;
    if (a === e) n_pass++;
    else $display("FAIL %s at cycle %0d: got %b expected %b", nm, cyc, a, e);
  endtask

  task automatic clr();
    LoadUseD = 0; DivE = 0; ExceptM = 0; IAddrOk = 0; IDataOk = 0;
    DMemM = 0; DAddrOk = 0; DDataOk = 0;
  endtask

  initial begin
    int rst_hold;
    rst = 0;
    clr();
    DivE = 1; DMemM = 1;
    step();
    chk("rst_ireq", IReq, 0); chk("rst_dreq", DReq, 0); chk("rst_divstart", DivStart, 0);
    chk("rst_stallf", StallF, 0); chk("rst_flushd", FlushD, 0);
    adv();
    clr();
    rst = 1;
    step();
    chk("first_ireq", IReq, 1);
    adv();

    // Lone divide
    clr(); DivE = 1;
    for (int c = 0; c <= 32; c++) begin
      step();
      chk(c == 0 ? "div_start" : "div_no_restart", DivStart, c == 0);
      if (c <= 31) begin
        chk("div_stalle", StallE, 1); chk("div_flushm", FlushM, 1); chk("div_notdone", DivDoneE, 0);
      end else begin
        chk("div_done", DivDoneE, 1); chk("div_release", StallE, 0);
      end
      adv();
    end
    clr(); step(); adv();

    // Load with grant in cycle 2 and data in cycle 5
    for (int c = 0; c <= 5; c++) begin
      clr(); DMemM = 1; DAddrOk = (c == 2); DDataOk = (c == 5);
      step();
      chk("ld_dreq", DReq, c <= 2); chk("ld_stallm", StallM, c <= 4); chk("ld_flushw", FlushW, c <= 4);
      adv();
    end
    clr(); step(); adv();

    // Divide finishing under a dmem stall waits, then a new divide can start
    for (int c = 0; c <= 37; c++) begin
      clr(); DivE = 1; DMemM = (c <= 36); DAddrOk = (c == 35); DDataOk = (c == 36);
      step();
      if (c == 32) begin chk("dd_done", DivDoneE, 1); chk("dd_hold", StallE, 1); end
      if (c >= 33 && c <= 36) begin chk("dd_nostart", DivStart, 0); chk("dd_nodone", DivDoneE, 0); end
      if (c >= 33 && c <= 35) chk("dd_stalle", StallE, 1);
      if (c == 36) chk("dd_stalle_drop", StallE, 0);
      if (c == 37) chk("dd_restart", DivStart, 1);
      adv();
    end
    clr(); ExceptM = 1;
    step(); chk("abort_stalle", StallE, 0); chk("abort_flushm", FlushM, 1);
    adv();

    // Exception while a fetch is in flight
    clr(); IAddrOk = 1; step(); chk("if_ireq", IReq, 1); adv();
    clr(); ExceptM = 1; step();
    chk("ex_flushd", FlushD, 1); chk("ex_flushe", FlushE, 1); chk("ex_flushm", FlushM, 1);
    chk("ex_flushw", FlushW, 1); chk("ex_stalld", StallD, 0); chk("ex_stalle", StallE, 0);
    chk("ex_stallm", StallM, 0); chk("ex_stallf", StallF, 1);
    adv();
    clr(); IDataOk = 1; step(); chk("ex_idiscard", IDiscard, 1); chk("ex_disc_stallf", StallF, 1); adv();
    clr(); step(); chk("ex_refetch", IReq, 1); adv();

    // Load-use bubble
    clr(); LoadUseD = 1; step();
    chk("lu_stallf", StallF, 1); chk("lu_stalld", StallD, 1); chk("lu_flushe", FlushE, 1); chk("lu_stalle", StallE, 0);
    adv();
    clr(); step(); chk("lu_stalld_off", StallD, 0); chk("lu_flushe_off", FlushE, 0); adv();

    // Reset in the middle of a divide
    clr(); DivE = 1;
    for (int c = 0; c <= 22; c++) begin step(); adv(); end
    rst = 0; step();
    chk("rr_divstart", DivStart, 0); chk("rr_stalle", StallE, 0); chk("rr_ireq", IReq, 0); chk("rr_done", DivDoneE, 0);
    adv(); step(); adv();
    rst = 1; step();
    chk("rr_ireq_after", IReq, 1); chk("rr_fresh_start", DivStart, 1);
    adv();

    // Random traffic
    rst_hold = 0;
    for (int i = 0; i < 3000; i++) begin
      LoadUseD = ($urandom_range(0, 99) < 15);
      DivE     = ($urandom_range(0, 99) < 30);
      IAddrOk  = ($urandom_range(0, 99) < 50);
      IDataOk  = ($urandom_range(0, 99) < 40);
      DMemM    = ($urandom_range(0, 99) < 30);
      DAddrOk  = ($urandom_range(0, 99) < 40);
      DDataOk  = ($urandom_range(0, 99) < 40);
      ExceptM  = !(dm_grant || dm_data) && ($urandom_range(0, 49) == 0);
      if (rst_hold == 0 && $urandom_range(0, 499) == 0) rst_hold = 2;
      rst = (rst_hold == 0);
      if (rst_hold > 0) rst_hold--;
      step();
      adv();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
